axi_generic_adc_pack: RTL and testbench

// Parametrised ADC-side channel packer; the data-path successor to the generic ADC register core.

---
 rtl/axi_generic_adc_pack_pkg.sv | 22 ++
 rtl/axi_generic_adc_pack_compact.sv | 60 ++++++
 rtl/axi_generic_adc_pack.sv | 114 +++++++++++
 tb/tb_axi_generic_adc_pack.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_generic_adc_pack_pkg.sv
// Shared definitions for the ADC channel packer: channel-count limit,
// pointer sizing and the popcount used to size each compacted sample set.
package axi_generic_adc_pack_pkg;

    localparam int MAX_CHANNELS = 16;
    localparam int COUNT_W      = 5;

    // Bits needed for a slot pointer that must also hold the value NUM_CHANNELS.
    function automatic int ptr_width(input int num_channels);
        return $clog2(num_channels) + 1;
    endfunction

    function automatic logic [COUNT_W-1:0] popcount(input logic [MAX_CHANNELS-1:0] bits);
        logic [COUNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            n = n + COUNT_W'(bits[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/axi_generic_adc_pack_compact.sv
// Stage 1 of the packer: squeezes the enabled channels of one sample set into
// slots 0..k-1 in ascending channel order and registers them with mask and k.
module adc_pack_compact
    import axi_generic_adc_pack_pkg::*;
#(
    parameter int  NUM_CHANNELS       = 4,
    parameter int  CHANNEL_DATA_WIDTH = 16,
    localparam int PTR_W              = ptr_width(NUM_CHANNELS),
    localparam int WORD_W             = NUM_CHANNELS * CHANNEL_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [NUM_CHANNELS-1:0] enable,
    input  logic [WORD_W-1:0]       data,
    output logic                    out_valid,
    output logic [NUM_CHANNELS-1:0] out_mask,
    output logic [WORD_W-1:0]       out_slots,
    output logic [PTR_W-1:0]        out_count
);

    logic [WORD_W-1:0] compact;
    logic [PTR_W-1:0]  count;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the loop can leave a bit unassigned and infer a latch.
    always_comb begin
        int idx;
        compact = '0;
        idx     = 0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (enable[i]) begin
                compact[idx*CHANNEL_DATA_WIDTH +: CHANNEL_DATA_WIDTH] =
                    data[i*CHANNEL_DATA_WIDTH +: CHANNEL_DATA_WIDTH];
                idx++;
            end
        end
        count = PTR_W'(popcount(MAX_CHANNELS'(enable)));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_mask  <= '0;
            out_slots <= '0;
            out_count <= '0;
        end else begin
            // The valid flag is a pulse; the payload holds while adc_valid is low.
            out_valid <= in_valid;
            if (in_valid) begin
                out_mask  <= enable;
                out_slots <= compact;
                out_count <= count;
            end
        end
    end

endmodule

// File: rtl/axi_generic_adc_pack.sv
// ADC-side channel packer: compacts enabled channels, appends them gaplessly
// into full-width DMA words and reports words dropped while the DMA stalls.
module axi_generic_adc_pack
    import axi_generic_adc_pack_pkg::*;
#(
    parameter int NUM_CHANNELS       = 4,
    parameter int CHANNEL_DATA_WIDTH = 16,
    parameter int OVF_COUNT_WIDTH    = 16
) (
    input  logic                                       adc_clk,
    input  logic                                       adc_rst,
    input  logic [NUM_CHANNELS-1:0]                    adc_enable,
    input  logic                                       adc_valid,
    input  logic [NUM_CHANNELS*CHANNEL_DATA_WIDTH-1:0] adc_data,
    output logic                                       dma_wr_valid,
    output logic [NUM_CHANNELS*CHANNEL_DATA_WIDTH-1:0] dma_wr_data,
    input  logic                                       dma_wr_ready,
    output logic                                       adc_dovf,
    output logic [OVF_COUNT_WIDTH-1:0]                 adc_ovf_count
);

    localparam int SLOT_W    = CHANNEL_DATA_WIDTH;
    localparam int PTR_W     = ptr_width(NUM_CHANNELS);
    localparam int WORD_W    = NUM_CHANNELS * SLOT_W;
    localparam int BUF_SLOTS = 2 * NUM_CHANNELS;

    logic                    s1_valid;
    logic [NUM_CHANNELS-1:0] s1_mask;
    logic [WORD_W-1:0]       s1_slots;
    logic [PTR_W-1:0]        s1_count;

    logic [BUF_SLOTS-1:0][SLOT_W-1:0] slot_buf, buf_next;
    logic [PTR_W-1:0]                 wr_ptr, ptr_next, base, fill;
    logic [NUM_CHANNELS-1:0]          last_mask, mask_next;
    logic                             emit;
    logic [WORD_W-1:0]                emit_word;

    adc_pack_compact #(
        .NUM_CHANNELS      (NUM_CHANNELS),
        .CHANNEL_DATA_WIDTH(CHANNEL_DATA_WIDTH)
    ) u_compact (
        .clk      (adc_clk),
        .rst      (adc_rst),
        .in_valid (adc_valid),
        .enable   (adc_enable),
        .data     (adc_data),
        .out_valid(s1_valid),
        .out_mask (s1_mask),
        .out_slots(s1_slots),
        .out_count(s1_count)
    );

    // Stage 2: append the compacted set at wr_ptr and peel off a word once full.
    always_comb begin
        buf_next  = slot_buf;
        ptr_next  = wr_ptr;
        mask_next = last_mask;
        emit      = 1'b0;
        emit_word = '0;
        // A new channel mask restarts packing so a word never mixes layouts.
        base      = (s1_mask != last_mask) ? '0 : wr_ptr;
        fill      = base + s1_count;
        if (s1_valid && s1_count != '0) begin
            mask_next = s1_mask;
            for (int j = 0; j < NUM_CHANNELS; j++) begin
                if (j < int'(s1_count)) begin
                    buf_next[int'(base) + j] = s1_slots[j*SLOT_W +: SLOT_W];
                end
            end
            if (fill >= PTR_W'(NUM_CHANNELS)) begin
                emit      = 1'b1;
                emit_word = buf_next[NUM_CHANNELS-1:0];
                buf_next  = buf_next >> WORD_W;
                ptr_next  = fill - PTR_W'(NUM_CHANNELS);
            end else begin
                ptr_next = fill;
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            // NOTE: the slot buffer is reset explicitly so a restart never
            // emits stale samples left over from before reset.
            slot_buf      <= '0;
            wr_ptr        <= '0;
            last_mask     <= '0;
            dma_wr_valid  <= 1'b0;
            dma_wr_data   <= '0;
            adc_dovf      <= 1'b0;
            adc_ovf_count <= '0;
        end else begin
            slot_buf  <= buf_next;
            wr_ptr    <= ptr_next;
            last_mask <= mask_next;
            adc_dovf  <= 1'b0;
            if (emit) begin
                if (!dma_wr_valid || dma_wr_ready) begin
                    dma_wr_valid <= 1'b1;
                    dma_wr_data  <= emit_word;
                end else begin
                    // Output slot busy: the new word is lost, the held word stays.
                    adc_dovf <= 1'b1;
                    if (adc_ovf_count != '1) begin
                        adc_ovf_count <= adc_ovf_count + OVF_COUNT_WIDTH'(1);
                    end
                end
            end else if (dma_wr_ready) begin
                dma_wr_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_generic_adc_pack.sv
// Bench for the ADC channel packer: directed scenarios plus randomized sample
// sets checked against a queue-based packing model.
module tb_axi_generic_adc_pack;

    logic        adc_clk = 1'b0;
    logic        adc_rst;
    logic [3:0]  adc_enable;
    logic        adc_valid;
    logic [63:0] adc_data;
    logic        dma_wr_valid;
    logic [63:0] dma_wr_data;
    logic        dma_wr_ready;
    logic        adc_dovf;
    logic [1:0]  adc_ovf_count;

    int total = 0;
    int bad   = 0;

    axi_generic_adc_pack #(
        .NUM_CHANNELS      (4),
        .CHANNEL_DATA_WIDTH(16),
        .OVF_COUNT_WIDTH   (2)
    ) dut (
        .adc_clk      (adc_clk),
        .adc_rst      (adc_rst),
        .adc_enable   (adc_enable),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .dma_wr_valid (dma_wr_valid),
        .dma_wr_data  (dma_wr_data),
        .dma_wr_ready (dma_wr_ready),
        .adc_dovf     (adc_dovf),
        .adc_ovf_count(adc_ovf_count)
    );

    always #5 adc_clk = ~adc_clk;

    // Reference model: a FIFO of pending samples, cut into 4-sample words.
    logic [15:0] pend[$];
    logic [63:0] exp_q[$];
    logic [3:0]  m_last = '0;

    task automatic model_reset();
        pend.delete();
        m_last = '0;
    endtask

    task automatic model_set(input logic [3:0] m, input logic [63:0] d);
        if (m == 4'b0000) return;
        if (m != m_last) begin
            pend.delete();
            m_last = m;
        end
        for (int i = 0; i < 4; i++) begin
            if (m[i]) pend.push_back(d[i*16 +: 16]);
        end
        while (pend.size() >= 4) begin
            exp_q.push_back({pend[3], pend[2], pend[1], pend[0]});
            repeat (4) void'(pend.pop_front());
        end
    endtask

    // Observed handshakes and overflow pulses, sampled mid-cycle.
    logic [63:0] got[$];
    int          dovf_seen = 0;

    always @(negedge adc_clk) begin
        if (!adc_rst && dma_wr_valid && dma_wr_ready) got.push_back(dma_wr_data);
        if (adc_dovf) dovf_seen++;
    end

    function automatic logic [15:0] chan(input int t, input int s, input int i);
        return 16'((t << 12) | (s << 8) | i);
    endfunction

    function automatic logic [63:0] make_set(input int t, input int s);
        logic [63:0] d;
        for (int i = 0; i < 4; i++) d[i*16 +: 16] = chan(t, s, i);
        return d;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge adc_clk);
            #1;
        end
    endtask

    task automatic drive_set(input logic [3:0] m, input logic [63:0] d);
        adc_enable = m;
        adc_data   = d;
        adc_valid  = 1'b1;
        model_set(m, d);
        @(posedge adc_clk);
        #1;
        adc_valid = 1'b0;
        adc_data  = {$urandom, $urandom};
    endtask

    task automatic do_reset();
        adc_rst = 1'b1;
        idle(1);
        adc_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        adc_rst      = 1'b1;
        adc_valid    = 1'b0;
        adc_enable   = 4'b0000;
        adc_data     = '0;
        dma_wr_ready = 1'b1;
        idle(2);
        total++;
        if (dma_wr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dma_wr_valid); end
        total++;
        if (dma_wr_data !== 64'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dma_wr_data); end
        total++;
        if (adc_dovf !== 1'b0) begin bad++; $display("FAIL reset_dovf got=%b exp=0", adc_dovf); end
        total++;
        if (adc_ovf_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", adc_ovf_count); end
        adc_rst = 1'b0;
        model_reset();
        idle(1);
    endtask

    task automatic test_full_mask();
        got.delete();
        exp_q.delete();
        dma_wr_ready = 1'b1;
        drive_set(4'b1111, make_set(1, 0));
        total++;
        if (dma_wr_valid !== 1'b0) begin bad++; $display("FAIL t1_early_valid got=%b exp=0", dma_wr_valid); end
        drive_set(4'b1111, make_set(1, 1));
        total++;
        if (dma_wr_valid !== 1'b1 || dma_wr_data !== make_set(1, 0)) begin
            bad++;
            $display("FAIL t1_latency valid=%b data=%h exp valid=1 data=%h", dma_wr_valid, dma_wr_data, make_set(1, 0));
        end
        drive_set(4'b1111, make_set(1, 2));
        idle(4);
        total++;
        if (got.size() != 3) begin bad++; $display("FAIL t1_words got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            logic [63:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            total++;
            if (g !== make_set(1, i) || g !== exp_q[i]) begin
                bad++;
                $display("FAIL t1_word%0d got=%h exp=%h", i, g, make_set(1, i));
            end
        end
    endtask

    task automatic test_sparse_mask();
        logic [63:0] want;
        got.delete();
        exp_q.delete();
        want = {chan(2, 1, 2), chan(2, 1, 0), chan(2, 0, 2), chan(2, 0, 0)};
        drive_set(4'b0101, make_set(2, 0));
        idle(3);
        total++;
        if (got.size() != 0) begin bad++; $display("FAIL t2_early got=%0d exp=0", got.size()); end
        drive_set(4'b0101, make_set(2, 1));
        idle(4);
        total++;
        if (got.size() != 1 || got[0] !== want || exp_q.size() != 1) begin
            bad++;
            $display("FAIL t2_word n=%0d got=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : 64'h0, want);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] want0;
        got.delete();
        exp_q.delete();
        want0 = {chan(3, 1, 0), chan(3, 0, 2), chan(3, 0, 1), chan(3, 0, 0)};
        for (int s = 0; s < 4; s++) drive_set(4'b0111, make_set(3, s));
        idle(4);
        total++;
        if (got.size() != exp_q.size() || got.size() != 3) begin
            bad++;
            $display("FAIL t3_words got=%0d exp=3", got.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [63:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            total++;
            if (g !== exp_q[i]) begin bad++; $display("FAIL t3_word%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        total++;
        if (got.size() > 0 && got[0] !== want0) begin bad++; $display("FAIL t3_word0_layout got=%h exp=%h", got[0], want0); end
    endtask

    task automatic test_mask_change();
        logic [63:0] want;
        got.delete();
        exp_q.delete();
        want = {chan(4, 2, 1), chan(4, 2, 0), chan(4, 1, 1), chan(4, 1, 0)};
        drive_set(4'b0111, make_set(4, 0));
        drive_set(4'b0011, make_set(4, 1));
        drive_set(4'b0011, make_set(4, 2));
        idle(4);
        total++;
        if (got.size() != 1 || got[0] !== want || exp_q.size() != 1) begin
            bad++;
            $display("FAIL t4_word n=%0d got=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : 64'h0, want);
        end
        // An all-zero mask must neither write nor disturb the pending partial word.
        got.delete();
        exp_q.delete();
        drive_set(4'b0011, make_set(4, 3));
        drive_set(4'b0000, make_set(4, 4));
        drive_set(4'b0011, make_set(4, 5));
        idle(4);
        want = {chan(4, 5, 1), chan(4, 5, 0), chan(4, 3, 1), chan(4, 3, 0)};
        total++;
        if (got.size() != 1 || got[0] !== want) begin
            bad++;
            $display("FAIL t4_zero_mask n=%0d got=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : 64'h0, want);
        end
    endtask

    task automatic test_stall();
        logic [63:0] w0;
        got.delete();
        exp_q.delete();
        dovf_seen    = 0;
        dma_wr_ready = 1'b0;
        for (int s = 0; s < 3; s++) drive_set(4'b1111, make_set(5, s));
        w0 = exp_q[0];
        for (int c = 0; c < 4; c++) begin
            total++;
            if (dma_wr_valid !== 1'b1 || dma_wr_data !== w0) begin
                bad++;
                $display("FAIL t5_hold%0d valid=%b data=%h exp=%h", c, dma_wr_valid, dma_wr_data, w0);
            end
            idle(1);
        end
        total++;
        if (dovf_seen != exp_q.size() - 1) begin bad++; $display("FAIL t5_dovf got=%0d exp=%0d", dovf_seen, exp_q.size() - 1); end
        total++;
        if (adc_ovf_count !== 2'd2) begin bad++; $display("FAIL t5_count got=%0d exp=2", adc_ovf_count); end
        dma_wr_ready = 1'b1;
        idle(3);
        total++;
        if (got.size() != 1 || got[0] !== w0) begin
            bad++;
            $display("FAIL t5_accept n=%0d got=%h exp=%h", got.size(), (got.size() > 0) ? got[0] : 64'h0, w0);
        end
        total++;
        if (dma_wr_valid !== 1'b0) begin bad++; $display("FAIL t5_drop_valid got=%b exp=0", dma_wr_valid); end
    endtask

    task automatic test_saturation_reset();
        logic [63:0] w0;
        do_reset();
        got.delete();
        exp_q.delete();
        dovf_seen    = 0;
        dma_wr_ready = 1'b0;
        for (int s = 0; s < 6; s++) drive_set(4'b1111, make_set(6, s));
        idle(3);
        w0 = exp_q[0];
        total++;
        if (adc_ovf_count !== 2'd3) begin bad++; $display("FAIL t6_sat got=%0d exp=3", adc_ovf_count); end
        total++;
        if (dovf_seen != 5) begin bad++; $display("FAIL t6_dovf got=%0d exp=5", dovf_seen); end
        total++;
        if (dma_wr_data !== w0) begin bad++; $display("FAIL t6_held got=%h exp=%h", dma_wr_data, w0); end
        drive_set(4'b0111, make_set(6, 9));
        adc_rst = 1'b1;
        idle(1);
        total++;
        if (dma_wr_valid !== 1'b0 || dma_wr_data !== 64'h0 || adc_dovf !== 1'b0 || adc_ovf_count !== 2'd0) begin
            bad++;
            $display("FAIL t6_reset valid=%b data=%h dovf=%b count=%0d exp all 0",
                     dma_wr_valid, dma_wr_data, adc_dovf, adc_ovf_count);
        end
        adc_rst = 1'b0;
        model_reset();
        got.delete();
        exp_q.delete();
        dma_wr_ready = 1'b1;
        for (int s = 0; s < 4; s++) drive_set(4'b0111, make_set(7, s));
        idle(4);
        total++;
        if (got.size() != 3 || got.size() != exp_q.size()) begin bad++; $display("FAIL t6_post_words got=%0d exp=3", got.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [63:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            total++;
            if (g !== exp_q[i]) begin bad++; $display("FAIL t6_post_word%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        total++;
        if (got.size() > 0 && got[0] !== {chan(7, 1, 0), chan(7, 0, 2), chan(7, 0, 1), chan(7, 0, 0)}) begin
            bad++;
            $display("FAIL t6_aligned got=%h exp=%h", got[0], {chan(7, 1, 0), chan(7, 0, 2), chan(7, 0, 1), chan(7, 0, 0)});
        end
    endtask

    task automatic test_random();
        logic [3:0] pool[7];
        logic [3:0] m;
        pool = '{4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b1000, 4'b0000, 4'b1010};
        got.delete();
        exp_q.delete();
        dma_wr_ready = 1'b1;
        m = 4'b0111;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 4) == 0) m = pool[$urandom_range(0, 6)];
            drive_set(m, {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) idle(1);
        end
        idle(4);
        total++;
        if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand_words got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [63:0] g;
            g = (i < got.size()) ? got[i] : 'x;
            total++;
            if (g !== exp_q[i]) begin bad++; $display("FAIL rand_word%0d got=%h exp=%h", i, g, exp_q[i]); end
        end
        total++;
        if (adc_ovf_count !== 2'd0) begin bad++; $display("FAIL rand_count got=%0d exp=0", adc_ovf_count); end
    endtask

    initial begin
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_wrap();
        test_mask_change();
        test_stall();
        test_saturation_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
